// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg
// Shared SAP-2 control-path definitions: opcode encoding, per-opcode operand
// byte table, instruction length helper and the instruction assembler's
// state encoding.
//   opcode_t                  : SAP-2 opcode byte values
//   asm_state_t               : instruction assembler states
//   OPERAND_BYTES_MAX_DEFAULT : default operand byte capacity
//   op_info()                 : table lookup (listed flag + operand bytes)
//   len_of()                  : 1 + operand byte count, unsaturated
package arch_defs_pkg;

  localparam int OPERAND_BYTES_MAX_DEFAULT = 2;
  localparam int OPCODE_WIDTH              = 8;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP    = 8'h00, OP_INR_B = 8'h04, OP_DCR_B = 8'h05, OP_MVI_B = 8'h06,
    OP_INR_C  = 8'h0C, OP_DCR_C = 8'h0D, OP_MVI_C = 8'h0E, OP_CMA   = 8'h2F,
    OP_STA    = 8'h32, OP_LDA   = 8'h3A, OP_INR_A = 8'h3C, OP_DCR_A = 8'h3D,
    OP_MVI_A  = 8'h3E, OP_HLT   = 8'h76, OP_MOV_AB = 8'h78, OP_ADD_B = 8'h80,
    OP_SUB_B  = 8'h90, OP_ANA_B = 8'hA0, OP_ORA_B = 8'hB0, OP_JNZ   = 8'hC2,
    OP_JMP    = 8'hC3, OP_RET   = 8'hC9, OP_JZ    = 8'hCA, OP_CALL  = 8'hCD,
    OP_OUT    = 8'hD3, OP_IN    = 8'hDB, OP_ANI   = 8'hE6, OP_ORI   = 8'hF6,
    OP_JM     = 8'hFA
  } opcode_t;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_OPERAND = 2'd1,
    S_READY   = 2'd2
  } asm_state_t;

  typedef struct packed {
    logic       listed;
    logic [2:0] operand_bytes;
  } op_info_t;

  // Unlisted encodings report listed=0 and zero operand bytes, which makes
  // them single-byte instructions everywhere downstream.
  function automatic op_info_t op_info(opcode_t op);
    op_info_t info;
    info.listed        = 1'b1;
    info.operand_bytes = 3'd0;
    case (op)
      OP_MVI_A, OP_MVI_B, OP_MVI_C, OP_ANI, OP_ORI, OP_IN, OP_OUT:
        info.operand_bytes = 3'd1;
      OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_JNZ, OP_JM, OP_CALL:
        info.operand_bytes = 3'd2;
      OP_NOP, OP_INR_A, OP_INR_B, OP_INR_C, OP_DCR_A, OP_DCR_B, OP_DCR_C,
      OP_CMA, OP_HLT, OP_MOV_AB, OP_ADD_B, OP_SUB_B, OP_ANA_B, OP_ORA_B,
      OP_RET:
        info.operand_bytes = 3'd0;
      default:
        info.listed = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic [2:0] len_of(opcode_t op);
    op_info_t info;
    info = op_info(op);
    return 3'd1 + info.operand_bytes;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// instr_len_decode
// Combinational opcode -> instruction length decoder, shared with the
// controller. Lengths are capped at OPERAND_BYTES_MAX+1.
//   opcode  in  opcode_t : opcode byte to classify
//   len     out 3        : total instruction length in bytes
//   illegal out 1        : opcode is not in the length table
module instr_len_decode
  import arch_defs_pkg::*;
#(
  parameter int OPERAND_BYTES_MAX = OPERAND_BYTES_MAX_DEFAULT
) (
  input  opcode_t    opcode,
  output logic [2:0] len,
  output logic       illegal
);

  localparam logic [2:0] LEN_CAP = 3'(OPERAND_BYTES_MAX + 1);

  op_info_t   info;
  logic [2:0] raw_len;

  always_comb begin
    info    = op_info(opcode);
    raw_len = len_of(opcode);
    illegal = ~info.listed;
    len     = (raw_len > LEN_CAP) ? LEN_CAP : raw_len;
  end

endmodule

// File: rtl/instruction_assembler.sv
// instruction_assembler
// Collects a variable-length SAP-2 instruction (opcode + 0..OPERAND_BYTES_MAX
// operand bytes) one byte per load strobe and presents opcode and
// little-endian operand with a valid flag.
// Optional feature macro: ILLEGAL_TRAP_EN (adds the illegal output).
//   clk         in  1        : system clock, rising edge
//   reset_n     in  1        : asynchronous active-low reset
//   load        in  1        : data_in carries the next instruction byte
//   data_in     in  DW       : instruction byte from the memory bus
//   abort       in  1        : discard partial/complete instruction
//   opcode      out opcode_t : captured opcode
//   operand     out DW*N     : operand bytes, little-endian
//   instr_len   out 3        : total byte count of current instruction
//   need_byte   out 1        : another operand byte is expected
//   instr_valid out 1        : opcode and operand complete
//   illegal     out 1        : opcode not in table (ILLEGAL_TRAP_EN only)
module instruction_assembler
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int OPERAND_BYTES_MAX = OPERAND_BYTES_MAX_DEFAULT,
  // A zero-operand build still needs a legal port width; the bit stays 0.
  localparam int OPERAND_W = (OPERAND_BYTES_MAX > 0) ? DATA_WIDTH * OPERAND_BYTES_MAX : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  abort,
  output opcode_t               opcode,
  output logic [OPERAND_W-1:0]  operand,
  output logic [2:0]            instr_len,
  output logic                  need_byte,
  output logic                  instr_valid
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  illegal
`endif
);

  asm_state_t state_reg, state_next;
  logic [2:0] cnt_reg;
  opcode_t    opcode_reg;
  logic [2:0] len_reg;
  opcode_t    bus_opcode;
  logic [2:0] dec_len;
  logic       dec_illegal;
  logic [2:0] cap_len;
  logic       capture;
  logic       operand_wr;

  assign bus_opcode = opcode_t'(data_in[OPCODE_WIDTH-1:0]);

  instr_len_decode #(
    .OPERAND_BYTES_MAX(OPERAND_BYTES_MAX)
  ) u_len_decode (
    .opcode (bus_opcode),
    .len    (dec_len),
    .illegal(dec_illegal)
  );

  // Unknown opcodes are single-byte so the controller always sees them
  // complete (and can trap when the illegal flag is built in).
  assign cap_len    = dec_illegal ? 3'd1 : dec_len;
  assign capture    = load && !abort && (state_reg != S_OPERAND);
  assign operand_wr = load && !abort && (state_reg == S_OPERAND);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_EMPTY;
    else          state_reg <= state_next;
  end

  // Next-state logic; abort wins over load
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_EMPTY;
    end else if (load) begin
      case (state_reg)
        S_EMPTY, S_READY: state_next = (cap_len == 3'd1) ? S_READY : S_OPERAND;
        S_OPERAND:        if (cnt_reg + 3'd1 == len_reg - 3'd1) state_next = S_READY;
        default:          state_next = S_EMPTY;
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    need_byte   = (state_reg == S_OPERAND);
    instr_valid = (state_reg == S_READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_reg <= OP_NOP;
      len_reg    <= 3'd1;
      cnt_reg    <= 3'd0;
    end else if (abort) begin
      cnt_reg <= 3'd0;
    end else if (capture) begin
      opcode_reg <= bus_opcode;
      len_reg    <= cap_len;
      cnt_reg    <= 3'd0;
    end else if (operand_wr) begin
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

  assign opcode    = opcode_reg;
  assign instr_len = len_reg;

  // One register per operand byte; a new opcode clears them all so bytes
  // beyond the instruction length read as zero.
  generate
    if (OPERAND_BYTES_MAX > 0) begin : g_operand
      logic [DATA_WIDTH-1:0] byte_reg [OPERAND_BYTES_MAX];
      for (genvar gi = 0; gi < OPERAND_BYTES_MAX; gi++) begin : g_byte
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)                               byte_reg[gi] <= '0;
          else if (capture)                           byte_reg[gi] <= '0;
          else if (operand_wr && cnt_reg == 3'(gi))   byte_reg[gi] <= data_in;
        end
        assign operand[gi*DATA_WIDTH +: DATA_WIDTH] = byte_reg[gi];
      end
    end else begin : g_no_operand
      assign operand = '0;
    end
  endgenerate

`ifdef ILLEGAL_TRAP_EN
  logic illegal_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     illegal_reg <= 1'b0;
    else if (abort)   illegal_reg <= 1'b0;
    else if (capture) illegal_reg <= dec_illegal;
  end
  assign illegal = illegal_reg;
`endif

endmodule

// File: tb/tb_instruction_assembler.sv
module tb_instruction_assembler;
  import arch_defs_pkg::*;

  localparam int MAXB = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  data_in = 8'h00;
  opcode_t     opcode;
  logic [15:0] operand;
  logic [2:0]  instr_len;
  logic        need_byte;
  logic        instr_valid;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  instruction_assembler #(
    .DATA_WIDTH(8),
    .OPERAND_BYTES_MAX(MAXB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .data_in(data_in),
    .abort(abort),
    .opcode(opcode),
    .operand(operand),
    .instr_len(instr_len),
    .need_byte(need_byte),
    .instr_valid(instr_valid)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference opcode table: SAP-2 instruction set lengths.
  logic [7:0] tab_code [29] = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h0C, 8'h0D, 8'h0E, 8'h2F,
                                8'h32, 8'h3A, 8'h3C, 8'h3D, 8'h3E, 8'h76, 8'h78, 8'h80,
                                8'h90, 8'hA0, 8'hB0, 8'hC2, 8'hC3, 8'hC9, 8'hCA, 8'hCD,
                                8'hD3, 8'hDB, 8'hE6, 8'hF6, 8'hFA};
  int         tab_ops  [29] = '{0, 0, 0, 1, 0, 0, 1, 0,
                                2, 2, 0, 0, 1, 0, 0, 0,
                                0, 0, 0, 2, 2, 0, 2, 2,
                                1, 1, 1, 1, 2};

  // Model: bytes of the current instruction, plus whether the assembler is empty.
  logic [7:0] q[$];
  bit         m_empty = 1'b1;
  bit         m_illegal = 1'b0;

  function automatic int ref_ops(logic [7:0] code, output bit listed);
    int ops = 0;
    listed = 1'b0;
    foreach (tab_code[i]) if (tab_code[i] == code) begin listed = 1'b1; ops = tab_ops[i]; end
    return ops;
  endfunction

  function automatic int ref_len(logic [7:0] code);
    bit listed;
    int l;
    l = 1 + ref_ops(code, listed);
    if (l > MAXB + 1) l = MAXB + 1;
    return l;
  endfunction

  task automatic model_clock(bit ld, logic [7:0] d, bit ab);
    bit listed;
    int unused_ops;
    if (ab) begin
      m_empty = 1'b1;
      m_illegal = 1'b0;
    end else if (ld) begin
      if (m_empty || q.size() == ref_len(q[0])) begin
        q = {d};
        m_empty = 1'b0;
        unused_ops = ref_ops(d, listed);
        m_illegal = !listed;
      end else begin
        q.push_back(d);
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_empty = 1'b1;
    m_illegal = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [7:0]  e_op;
    logic [15:0] e_operand;
    int          e_len;
    bit          full;
    e_op = (q.size() > 0) ? q[0] : 8'h00;
    e_operand = 16'h0000;
    for (int i = 1; i < q.size(); i++) e_operand = e_operand | (16'(q[i]) << (8 * (i - 1)));
    e_len = (q.size() > 0) ? ref_len(q[0]) : 1;
    full = (q.size() == e_len);
    chk({tag, "/opcode"},      32'(opcode),      32'(e_op));
    chk({tag, "/operand"},     32'(operand),     32'(e_operand));
    chk({tag, "/instr_len"},   32'(instr_len),   32'(e_len));
    chk({tag, "/instr_valid"}, 32'(instr_valid), 32'(!m_empty && full));
    chk({tag, "/need_byte"},   32'(need_byte),   32'(!m_empty && !full));
`ifdef ILLEGAL_TRAP_EN
    chk({tag, "/illegal"},     32'(illegal),     32'(m_illegal));
`endif
  endtask

  task automatic step(bit ld, logic [7:0] d, bit ab, string tag);
    load = ld;
    data_in = d;
    abort = ab;
    @(posedge clk);
    model_clock(ld, d, ab);
    #1;
    load = 1'b0;
    abort = 1'b0;
    check_all(tag);
    $display("[%0t] %s load=%0b data=%02h abort=%0b -> op=%02h operand=%04h len=%0d need=%0b valid=%0b",
             $time, tag, ld, d, ab, opcode, operand, instr_len, need_byte, instr_valid);
  endtask

  task automatic async_reset(string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, "/opcode_zero"}, 32'(opcode), 32'h0);
    $display("[%0t] %s reset applied -> op=%02h len=%0d valid=%0b", $time, tag, opcode, instr_len, instr_valid);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bit         ab, ld;
    logic [7:0] d;
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // Latch 8'hFF, then reset asynchronously between clock edges
    step(1'b1, 8'hFF, 1'b0, "latch_ff");
    chk("latch_ff/opcode_ff", 32'(opcode), 32'hFF);
    async_reset("async_reset");

    // Single-byte NOP
    step(1'b1, 8'h00, 1'b0, "nop");
    chk("nop/valid", 32'(instr_valid), 32'h1);

    // 3-byte LDA with two idle cycles between bytes
    step(1'b1, 8'h3A, 1'b0, "lda_op");
    step(1'b0, 8'h00, 1'b0, "lda_gap");
    step(1'b0, 8'h00, 1'b0, "lda_gap");
    step(1'b1, 8'h34, 1'b0, "lda_lo");
    step(1'b0, 8'h00, 1'b0, "lda_gap");
    step(1'b0, 8'h00, 1'b0, "lda_gap");
    step(1'b1, 8'h12, 1'b0, "lda_hi");
    chk("lda/operand_1234", 32'(operand), 32'h1234);
    step(1'b0, 8'h00, 1'b0, "lda_hold");

    // MVI then a 1-byte opcode straight out of READY
    step(1'b1, 8'h3E, 1'b0, "mvi_op");
    step(1'b1, 8'hA5, 1'b0, "mvi_imm");
    step(1'b1, 8'h3C, 1'b0, "b2b_inr");
    chk("b2b/operand_zero", 32'(operand), 32'h0);

    // Abort alongside the second byte of LDA, then a clean restart
    step(1'b1, 8'h3A, 1'b0, "abort_op");
    step(1'b1, 8'h55, 1'b1, "abort_hit");
    step(1'b1, 8'h06, 1'b0, "after_abort_op");
    step(1'b1, 8'h77, 1'b0, "after_abort_imm");
    chk("after_abort/operand", 32'(operand), 32'h0077);

    // Reset while mid-instruction
    step(1'b1, 8'hCD, 1'b0, "mid_op");
    step(1'b1, 8'h11, 1'b0, "mid_lo");
    async_reset("mid_reset");

`ifdef ILLEGAL_TRAP_EN
    step(1'b1, 8'hEE, 1'b0, "illegal_ee");
    chk("illegal_ee/flag", 32'(illegal), 32'h1);
    step(1'b1, 8'h00, 1'b0, "illegal_clear");
    chk("illegal_clear/flag", 32'(illegal), 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ab = ($urandom_range(0, 99) < 5);
      ld = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 1) == 1) d = tab_code[$urandom_range(0, 28)];
      else                           d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
      else step(ld, d, ab, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
